// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: shares one async-FIFO read port among NUM_REQ consumers.
// Round-robin grant, up to BURST words per grant. Each word takes three
// cycles (FETCH -> LOAD -> HOLD). There is at most one read in flight, and
// the word is delivered to the granted consumer over valid/ready.
module fifo_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int BURST   = 8
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rempty,
    input  logic [DATA_W-1:0]  rdata,
    input  logic               out_ready,
    output logic               r_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               burst_end
);

    localparam int CNT_W = $clog2(BURST + 1);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [2:0] S_BLANK   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               blank_q, blank_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     scan;
    logic [IDX_W-1:0]   rr_next;

    // Find the first requester at or after the rr pointer, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (scan >= (IDX_W+1)'(NUM_REQ))
                scan = scan - (IDX_W+1)'(NUM_REQ);
            if (!pick_vld && req[scan[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[IDX_W-1:0];
            end
        end
        rr_next = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end

    // Grant / fetch sequencing. rempty is ignored during the two BLANK cycles
    // because it sits low while the read-side module comes out of reset.
    always_comb begin
        state_d     = state_q;
        blank_d     = blank_q;
        rr_d        = rr_q;
        gidx_d      = gidx_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_BLANK: begin
                if (blank_q) state_d = S_IDLE;
                else         blank_d = 1'b1;
            end
            S_IDLE: begin
                if (pick_vld && !rempty) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    state_d         = S_FETCH;
                end
            end
            S_FETCH: begin
                // The read is issued combinationally here only when data exists.
                if (rempty) begin
                    gnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                out_data_d  = rdata;
                out_valid_d = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                out_last_d  = (cnt_q + 1'b1) == CNT_W'(BURST);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (cnt_q == CNT_W'(BURST) || !req[gidx_q] || rempty) begin
                        gnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_RELEASE: begin
                cnt_d   = '0;
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= S_BLANK;
            blank_q     <= 1'b0;
            rr_q        <= '0;
            gidx_q      <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_q     <= blank_d;
            rr_q        <= rr_d;
            gidx_q      <= gidx_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign r_en      = (state_q == S_FETCH) && !rempty;
    assign burst_end = (state_q == S_RELEASE);
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: a cycle-vector table for reset/first bursts,
// directed multi-cycle sequences, then random traffic against a
// transaction-level model (word order, rr grant order, burst length rules).
module tb_fifo_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int BURST   = 8;

    logic               rclk = 1'b0;
    logic               rrst_n;
    logic [NUM_REQ-1:0] req;
    logic               rempty;
    logic [DATA_W-1:0]  rdata;
    logic               out_ready;
    logic               r_en;
    logic [NUM_REQ-1:0] gnt;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;
    logic               burst_end;

    fifo_read_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST(BURST)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .req(req), .rempty(rempty), .rdata(rdata),
        .out_ready(out_ready), .r_en(r_en), .gnt(gnt), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .burst_end(burst_end)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // FIFO read side + memory model: registered empty flag, 1-cycle read data.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] pop_tmp;
    int                fn;

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rempty <= 1'b0;
            rdata  <= '0;
        end else begin
            fn = fifo_q.size();
            if (r_en && fn > 0) begin
                pop_tmp = fifo_q.pop_front();
                rdata  <= pop_tmp;
                fn     = fn - 1;
            end
            rempty <= (fn == 0);
        end
    end

    // Transaction-level model state
    int                 ptr, gidx_m, words, n_be, n_acc, n_ren;
    logic               any_last;
    logic [NUM_REQ-1:0] prev_gnt;
    logic [NUM_REQ-1:0] grant_log[$];
    int                 len_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (p + i) % NUM_REQ;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word();
        fifo_q.push_back(seq);
        exp_q.push_back(seq);
        seq = seq + 1'b1;
    endtask

    task automatic mdl_reset();
        fifo_q.delete(); exp_q.delete(); grant_log.delete(); len_log.delete();
        seq = 8'hA0; ptr = 0; gidx_m = 0; words = 0; n_be = 0; n_acc = 0; n_ren = 0;
        any_last = 1'b0; prev_gnt = '0;
    endtask

    // Hold reset two cycles with nwords preloaded, release just after an edge.
    task automatic do_reset(input int nwords);
        rrst_n = 1'b0; req = '0; out_ready = 1'b0;
        mdl_reset();
        for (int i = 0; i < nwords; i++) push_word();
        step(); step();
        rrst_n = 1'b1;
    endtask

    // One clock with model tracking; inputs for this edge are already driven.
    task automatic cyc();
        logic [NUM_REQ-1:0] r0;
        r0 = req;
        if (out_valid && out_ready) begin
            words++; n_acc++;
            if (exp_q.size() > 0) chk("data_order", out_data, exp_q.pop_front());
            else                  chk("data_extra", 1, 0);
            chk("out_last", out_last, words == BURST);
            if (out_last) any_last = 1'b1;
        end
        step();
        chk("ren_while_empty", r_en & rempty, 0);
        chk("ren_while_valid", r_en & out_valid, 0);
        chk("gnt_onehot", $countones(gnt) <= 1, 1);
        if (r_en) n_ren++;
        if (gnt != 0 && prev_gnt == 0) begin
            gidx_m = pick(r0, ptr);
            chk("gnt_rr", gnt, 1 << gidx_m);
            grant_log.push_back(gnt);
            words = 0;
        end else if (gnt != 0) begin
            chk("gnt_held", gnt, prev_gnt);
        end
        if (burst_end) begin
            n_be++;
            chk("burst_len_max", words <= BURST, 1);
            chk("gnt_low_at_end", gnt, 0);
            ptr = (gidx_m + 1) % NUM_REQ;
            len_log.push_back(words);
        end
        prev_gnt = gnt;
    endtask

    task automatic wait_be(input int target, input int bound, input string nm);
        int c;
        c = 0;
        while (n_be < target && c < bound) begin cyc(); c++; end
        chk(nm, n_be >= target, 1);
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic               rdy;
        logic [NUM_REQ-1:0] gnt;
        logic               ren;
        logic               ov;
        logic [DATA_W-1:0]  dat;
        logic               last;
        logic               be;
    } vec_t;

    vec_t tv[29];
    logic [NUM_REQ-1:0] exp_gnts[5];
    logic [DATA_W-1:0]  held;
    int                 cnt, a0;

    initial begin
        // Cycle k (1-based, sampled after the k-th edge past reset release):
        // 2 blanking cycles, IDLE, then FETCH/LOAD/HOLD per word.
        for (int k = 1; k <= 29; k++) begin
            int p, w;
            tv[k-1] = '{req: 4'b0001, rdy: 1'b1, gnt: '0, ren: 1'b0, ov: 1'b0,
                        dat: '0, last: 1'b0, be: 1'b0};
            if (k >= 3 && k <= 26) begin
                p = (k - 3) % 3;
                w = (k - 3) / 3;
                tv[k-1].gnt  = 4'b0001;
                tv[k-1].ren  = (p == 0);
                tv[k-1].ov   = (p == 2);
                tv[k-1].dat  = 8'hA0 + 8'(w);
                tv[k-1].last = (p == 2) && (w == BURST - 1);
            end
            if (k == 27) tv[k-1].be = 1'b1;
            if (k == 29) begin tv[k-1].gnt = 4'b0001; tv[k-1].ren = 1'b1; end
        end
        exp_gnts = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values
        rrst_n = 1'b0; req = '0; out_ready = 1'b0;
        mdl_reset();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_ren", r_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_be", burst_end, 0);

        // Blanking, first grant, 8-word burst, regrant to req0
        do_reset(20);
        for (int i = 0; i < 29; i++) begin
            req = tv[i].req; out_ready = tv[i].rdy;
            cyc();
            chk($sformatf("tv%0d_gnt", i + 1), gnt, tv[i].gnt);
            chk($sformatf("tv%0d_ren", i + 1), r_en, tv[i].ren);
            chk($sformatf("tv%0d_valid", i + 1), out_valid, tv[i].ov);
            chk($sformatf("tv%0d_last", i + 1), out_last, tv[i].last);
            chk($sformatf("tv%0d_be", i + 1), burst_end, tv[i].be);
            if (tv[i].ov) chk($sformatf("tv%0d_data", i + 1), out_data, tv[i].dat);
        end

        // All four requesting: round-robin order, 8 words each
        do_reset(48);
        req = 4'b1111; out_ready = 1'b1;
        wait_be(5, 400, "rr_timeout");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_gnt%0d", i), (grant_log.size() > i) ? grant_log[i] : 4'b0, exp_gnts[i]);
            chk($sformatf("rr_len%0d", i), (len_log.size() > i) ? len_log[i] : 0, BURST);
        end

        // Short FIFO: burst ends on empty, no out_last, no reads while empty
        do_reset(3);
        req = 4'b0001; out_ready = 1'b1;
        wait_be(1, 60, "short_timeout");
        chk("short_len", (len_log.size() > 0) ? len_log[0] : -1, 3);
        chk("short_no_last", any_last, 0);
        n_ren = 0;
        repeat (6) cyc();
        chk("short_no_ren", n_ren, 0);

        // Backpressure in HOLD
        do_reset(5);
        req = 4'b0001; out_ready = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin cyc(); cnt++; end
        chk("bp_valid_seen", out_valid, 1);
        held = out_data;
        n_ren = 0;
        repeat (10) begin
            cyc();
            chk("bp_data_stable", out_data, held);
            chk("bp_valid_held", out_valid, 1);
        end
        chk("bp_no_ren", n_ren, 0);
        a0 = n_acc;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_valid_drop", out_valid, 0);
        repeat (4) cyc();
        chk("bp_one_xfer", n_acc - a0, 1);

        // Reset mid-burst in LOAD; rr pointer must restart at 0
        do_reset(2);
        req = 4'b0010; out_ready = 1'b1;
        wait_be(1, 60, "mid_pre_timeout");
        push_word(); push_word(); push_word(); push_word();
        cnt = 0;
        while (!r_en && cnt < 20) begin cyc(); cnt++; end
        chk("mid_fetch_seen", r_en, 1);
        cyc();
        chk("mid_load_gnt", gnt, 4'b0010);
        rrst_n = 1'b0;
        #1;
        chk("mid_async_gnt", gnt, 0);
        step();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ren", r_en, 0);
        mdl_reset();
        for (int i = 0; i < 6; i++) push_word();
        rrst_n = 1'b1;
        req = 4'b1111;
        cyc();
        chk("mid_blank1_ren", r_en, 0);
        cyc();
        chk("mid_blank2_ren", r_en, 0);
        chk("mid_blank2_gnt", gnt, 0);
        cyc();
        chk("mid_regrant", gnt, 4'b0001);
        chk("mid_regrant_ren", r_en, 1);

        // Random traffic against the model
        do_reset(6);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 12 && $urandom_range(0, 2) == 0) push_word();
            cyc();
        end
        chk("rand_progress", n_acc > 100, 1);
        chk("rand_bursts", n_be > 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
